layer10_train_sequencer: RTL and testbench

Sequencer for one 10-output learning layer, the `neuron_learn_layer10` datapath, with N inputs. It accepts labelled samples over a valid/ready stream and drives the layer's `in`, `valid`, `learn` and one-hot `expected_out` ports. After a fixed settle time it scans the 10 outputs sequentially for the argmax and returns the predicted class with a correctness flag over a second valid/ready stream. It keeps saturating total/correct statistics counters for training and inference runs.

---
 rtl/layer10_train_sequencer.sv | 172 +++++++++++++++++
 tb/tb_layer10_train_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer10_train_sequencer.sv
// Sequences one labelled sample through a 10-output learning layer, scans the outputs for the
// argmax, returns class/correct over a valid/ready stream and keeps saturating statistics counters.
module layer10_train_sequencer #(
  parameter int             N         = 16,
  parameter int             DW        = 8,
  parameter int             LAT       = 2,
  parameter int             CNT_W     = 16,
  parameter logic [DW-1:0]  TARGET_HI = '1,
  parameter logic [DW-1:0]  TARGET_LO = '0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [N*DW-1:0]     s_in,
  input  logic [3:0]          s_label,
  input  logic                s_learn,
  output logic [N*DW-1:0]     l_in,
  output logic                l_valid,
  output logic                l_learn,
  output logic [10*DW-1:0]    l_expected,
  input  logic [10*DW-1:0]    l_out,
  output logic                r_valid,
  input  logic                r_ready,
  output logic [3:0]          r_class,
  output logic                r_correct,
  output logic                r_bad_label,
  input  logic                clear_stats,
  output logic [CNT_W-1:0]    total_cnt,
  output logic [CNT_W-1:0]    correct_cnt,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, EVAL, RESULT} state_t;

  localparam logic [7:0] LAT_M1 = 8'(LAT - 1);

  state_t              r_state, w_state_nxt;
  logic [N*DW-1:0]     r_data;
  logic [10*DW-1:0]    r_exp;
  logic [3:0]          r_label;
  logic                r_learn;
  logic [7:0]          r_settle;
  logic [3:0]          r_idx;
  logic [DW-1:0]       r_best;
  logic [3:0]          r_best_idx;
  logic [3:0]          r_cls;
  logic                r_corr;
  logic                r_bad;
  logic [CNT_W-1:0]    r_total;
  logic [CNT_W-1:0]    r_corr_cnt;

  logic [10*DW-1:0]    w_exp_in;
  logic [DW-1:0]       w_cur;
  logic                w_take;
  logic [3:0]          w_win;
  logic                w_legal;
  logic                w_correct;
  logic                w_exit;

  // One-hot target built from the incoming label; an illegal label matches no lane.
  always_comb begin
    w_exp_in = '0;
    for (int k = 0; k < 10; k++) begin
      w_exp_in[k*DW +: DW] = (s_label == k[3:0]) ? TARGET_HI : TARGET_LO;
    end
  end

  always_comb begin
    w_cur = '0;
    for (int k = 0; k < 10; k++) begin
      if (r_idx == k[3:0]) w_cur = l_out[k*DW +: DW];
    end
  end

  // Strictly-greater replacement keeps the lowest index on ties.
  assign w_take    = (r_idx == 4'd0) || (w_cur > r_best);
  assign w_win     = w_take ? r_idx : r_best_idx;
  assign w_legal   = (r_label < 4'd10);
  assign w_correct = w_legal && (w_win == r_label);
  assign w_exit    = (r_state == EVAL) && (r_idx == 4'd9);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (s_valid) w_state_nxt = APPLY;
      APPLY:   w_state_nxt = SETTLE;
      SETTLE:  if (r_settle == 8'd0) w_state_nxt = EVAL;
      EVAL:    if (r_idx == 4'd9) w_state_nxt = RESULT;
      RESULT:  if (r_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= '0;
      r_exp      <= '0;
      r_label    <= '0;
      r_learn    <= 1'b0;
      r_settle   <= '0;
      r_idx      <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_cls      <= '0;
      r_corr     <= 1'b0;
      r_bad      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_valid) begin
            r_data  <= s_in;
            r_label <= s_label;
            r_learn <= s_learn;
            r_exp   <= w_exp_in;
          end
        end
        APPLY: begin
          r_settle <= LAT_M1;
          r_idx    <= 4'd0;
        end
        SETTLE: r_settle <= r_settle - 8'd1;
        EVAL: begin
          if (w_take) begin
            r_best     <= w_cur;
            r_best_idx <= r_idx;
          end
          r_idx <= r_idx + 4'd1;
          if (r_idx == 4'd9) begin
            r_cls  <= w_win;
            r_corr <= w_correct;
            r_bad  <= ~w_legal;
          end
        end
        default: ;
      endcase
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_total    <= '0;
      r_corr_cnt <= '0;
    end else if (clear_stats) begin
      r_total    <= '0;
      r_corr_cnt <= '0;
    end else if (w_exit && w_legal) begin
      if (r_total != '1) r_total <= r_total + 1'b1;
      if (w_correct && (r_corr_cnt != '1)) r_corr_cnt <= r_corr_cnt + 1'b1;
    end
  end

  assign s_ready     = (r_state == IDLE);
  assign busy        = (r_state != IDLE);
  assign l_in        = r_data;
  assign l_expected  = r_exp;
  assign l_valid     = (r_state == APPLY);
  assign l_learn     = (r_state == APPLY) && r_learn && w_legal;
  assign r_valid     = (r_state == RESULT);
  assign r_class     = r_cls;
  assign r_correct   = r_corr;
  assign r_bad_label = r_bad;
  assign total_cnt   = r_total;
  assign correct_cnt = r_corr_cnt;

endmodule

// File: tb/tb_layer10_train_sequencer.sv
// Directed bench for layer10_train_sequencer (N=4, DW=8, LAT=2, CNT_W=3).
module tb_layer10_train_sequencer;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int LAT   = 2;
  localparam int CNT_W = 3;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                s_valid;
  logic                s_ready;
  logic [N*DW-1:0]     s_in;
  logic [3:0]          s_label;
  logic                s_learn;
  logic [N*DW-1:0]     l_in;
  logic                l_valid;
  logic                l_learn;
  logic [10*DW-1:0]    l_expected;
  logic [10*DW-1:0]    l_out;
  logic                r_valid;
  logic                r_ready;
  logic [3:0]          r_class;
  logic                r_correct;
  logic                r_bad_label;
  logic                clear_stats;
  logic [CNT_W-1:0]    total_cnt;
  logic [CNT_W-1:0]    correct_cnt;
  logic                busy;

  int checks = 0;
  int errors = 0;

  layer10_train_sequencer #(
    .N(N), .DW(DW), .LAT(LAT), .CNT_W(CNT_W),
    .TARGET_HI(8'hFF), .TARGET_LO(8'h00)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_in(s_in), .s_label(s_label), .s_learn(s_learn),
    .l_in(l_in), .l_valid(l_valid), .l_learn(l_learn), .l_expected(l_expected), .l_out(l_out),
    .r_valid(r_valid), .r_ready(r_ready), .r_class(r_class), .r_correct(r_correct),
    .r_bad_label(r_bad_label), .clear_stats(clear_stats),
    .total_cnt(total_cnt), .correct_cnt(correct_cnt), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Offers a sample and returns in the cycle after the accepting edge (APPLY).
  task automatic send(input logic [31:0] d, input logic [3:0] lab, input logic lrn);
    int n;
    s_in    = d;
    s_label = lab;
    s_learn = lrn;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 40) begin
      tick(1);
      n++;
    end
    if (!s_ready) chk("accept_timeout", 1'b0, 1'b1);
    tick(1);
    s_valid = 1'b0;
  endtask

  function automatic logic [79:0] lout_peak(input int p, input logic [7:0] v);
    logic [79:0] r;
    for (int i = 0; i < 10; i++) r[i*8 +: 8] = 8'(i * 3 + 1);
    r[p*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [79:0] onehot(input int lab);
    logic [79:0] r;
    r = '0;
    if (lab < 10) r[lab*8 +: 8] = 8'hFF;
    return r;
  endfunction

  logic [79:0] v;
  logic        seen;

  initial begin
    reset_n = 1'b0; s_valid = 1'b0; s_in = '0; s_label = '0; s_learn = 1'b0;
    l_out = '0; r_ready = 1'b1; clear_stats = 1'b0;
    #1;
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_l_valid", l_valid, 1'b0);
    chk("rst_r_valid", r_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_l_in", l_in, 0);
    chk("rst_l_exp", l_expected, 0);
    chk("rst_total", total_cnt, 0);
    chk("rst_class", r_class, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Label 3, training, peak at 3
    l_out = lout_peak(3, 8'hF0);
    send(32'h11223344, 4'd3, 1'b1);
    chk("t1_l_valid", l_valid, 1'b1);
    chk("t1_l_learn", l_learn, 1'b1);
    chk("t1_l_exp", l_expected, onehot(3));
    chk("t1_l_in", l_in, 32'h11223344);
    chk("t1_s_ready", s_ready, 1'b0);
    tick(1);
    chk("t1_pulse", l_valid, 1'b0);
    tick(11);
    chk("t1_rv_early", r_valid, 1'b0);
    tick(1);
    chk("t1_rv", r_valid, 1'b1);
    chk("t1_class", r_class, 4'd3);
    chk("t1_correct", r_correct, 1'b1);
    chk("t1_bad", r_bad_label, 1'b0);
    chk("t1_total", total_cnt, 3'd1);
    chk("t1_ccnt", correct_cnt, 3'd1);
    tick(1);
    chk("t1_idle", s_ready, 1'b1);
    chk("t1_hold_in", l_in, 32'h11223344);
    chk("t1_hold_exp", l_expected, onehot(3));

    // Tie between lanes 2 and 7, label 7, inference
    v = lout_peak(2, 8'hC0);
    v[7*8 +: 8] = 8'hC0;
    l_out = v;
    send(32'hA5A5_0F0F, 4'd7, 1'b0);
    chk("t2_l_valid", l_valid, 1'b1);
    chk("t2_l_learn", l_learn, 1'b0);
    chk("t2_l_exp", l_expected, onehot(7));
    tick(13);
    chk("t2_rv", r_valid, 1'b1);
    chk("t2_class", r_class, 4'd2);
    chk("t2_correct", r_correct, 1'b0);
    chk("t2_total", total_cnt, 3'd2);
    chk("t2_ccnt", correct_cnt, 3'd1);
    tick(1);

    // Illegal label 12, peak on last lane
    l_out = lout_peak(9, 8'h80);
    send(32'h0000_00FF, 4'd12, 1'b1);
    chk("t3_l_learn", l_learn, 1'b0);
    chk("t3_l_exp", l_expected, 0);
    tick(13);
    chk("t3_rv", r_valid, 1'b1);
    chk("t3_class", r_class, 4'd9);
    chk("t3_bad", r_bad_label, 1'b1);
    chk("t3_correct", r_correct, 1'b0);
    chk("t3_total", total_cnt, 3'd2);
    chk("t3_ccnt", correct_cnt, 3'd1);
    tick(1);

    // Backpressure: hold r_ready low for 20 cycles
    l_out = lout_peak(5, 8'h99);
    send(32'h5555_AAAA, 4'd5, 1'b1);
    r_ready = 1'b0;
    tick(13);
    chk("t4_rv", r_valid, 1'b1);
    s_in = 32'hDEAD_BEEF; s_label = 4'd1; s_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("t4_hold_rv", r_valid, 1'b1);
      chk("t4_hold_class", r_class, 4'd5);
      chk("t4_hold_corr", r_correct, 1'b1);
      chk("t4_s_ready", s_ready, 1'b0);
    end
    chk("t4_l_in", l_in, 32'h5555_AAAA);
    s_valid = 1'b0;
    r_ready = 1'b1;
    tick(1);
    chk("t4_idle", busy, 1'b0);
    chk("t4_rv_low", r_valid, 1'b0);
    chk("t4_total", total_cnt, 3'd3);
    chk("t4_ccnt", correct_cnt, 3'd2);

    // Drive counters to 7/6, then saturate
    l_out = lout_peak(0, 8'hEE);
    for (int i = 0; i < 4; i++) begin
      send(32'(i), 4'd0, 1'b1);
      tick(13);
      chk("t5_fill_rv", r_valid, 1'b1);
      tick(1);
    end
    chk("t5_pre_total", total_cnt, 3'd7);
    chk("t5_pre_ccnt", correct_cnt, 3'd6);
    l_out = lout_peak(6, 8'h77);
    send(32'h0606_0606, 4'd6, 1'b1);
    tick(13);
    chk("t5_sat_total", total_cnt, 3'd7);
    chk("t5_sat_ccnt", correct_cnt, 3'd7);
    tick(1);
    send(32'h0606_0606, 4'd6, 1'b1);
    tick(12);
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    chk("t5_clr_rv", r_valid, 1'b1);
    chk("t5_clr_total", total_cnt, 3'd0);
    chk("t5_clr_ccnt", correct_cnt, 3'd0);
    tick(1);

    // Reset during SETTLE
    l_out = lout_peak(4, 8'h44);
    send(32'h0404_0404, 4'd4, 1'b1);
    tick(13);
    chk("t6_pre_total", total_cnt, 3'd1);
    tick(1);
    send(32'h1234_5678, 4'd4, 1'b1);
    tick(1);
    chk("t6_in_settle", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_s_ready", s_ready, 1'b1);
    chk("t6_busy", busy, 1'b0);
    chk("t6_l_in", l_in, 0);
    chk("t6_l_exp", l_expected, 0);
    chk("t6_total", total_cnt, 3'd0);
    chk("t6_ccnt", correct_cnt, 3'd0);
    chk("t6_rv", r_valid, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (r_valid) seen = 1'b1;
    end
    chk("t6_no_rv", seen, 1'b0);
    l_out = lout_peak(1, 8'hB0);
    send(32'h0101_0101, 4'd1, 1'b1);
    chk("t6_post_l_valid", l_valid, 1'b1);
    tick(13);
    chk("t6_post_rv", r_valid, 1'b1);
    chk("t6_post_class", r_class, 4'd1);
    chk("t6_post_total", total_cnt, 3'd1);
    chk("t6_post_ccnt", correct_cnt, 3'd1);
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
